// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: clog2 helper and parameter-legality check shared by the FIFO files.
package sync_fifo_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic bit params_ok(input int depth, input int widthu);
        return depth >= 2 && (depth & (depth - 1)) == 0 && widthu == clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: DEPTH x WIDTH register array, synchronous write, asynchronous read.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 32,
    parameter int WIDTHU = 5
) (
    input  logic              clock,
    input  logic              i_we,
    input  logic [WIDTHU-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [WIDTHU-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with scfifo-compatible ports and overflow/underflow protection.
// Define SYNC_FIFO_SHOWAHEAD_EN for a show-ahead q; default is legacy registered q.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 32,
    parameter int WIDTHU = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  data,
    input  logic              wrreq,
    input  logic              rdreq,
    output logic [WIDTH-1:0]  q,
    output logic              empty,
    output logic              full,
    output logic [WIDTHU-1:0] usedw
);
    if (!params_ok(DEPTH, WIDTHU)) begin : g_bad_params
        $error("sync_fifo: DEPTH must be a power of two >= 2 and WIDTHU must equal log2(DEPTH)");
    end

    logic [WIDTHU-1:0] r_wptr, r_rptr;
    logic [WIDTHU:0]   r_count;
    logic [WIDTH-1:0]  w_rdata;
    logic              w_wr, w_rd;

    // count never exceeds DEPTH, so its top bit alone marks full
    assign empty = r_count == '0;
    assign full  = r_count[WIDTHU];
    assign usedw = r_count[WIDTHU-1:0];
    assign w_wr  = wrreq & ~full & reset_n;
    assign w_rd  = rdreq & ~empty;

    sync_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WIDTHU(WIDTHU)) u_ram (
        .clock   (clock),
        .i_we    (w_wr),
        .i_waddr (r_wptr),
        .i_wdata (data),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clock)
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + WIDTHU'(1);
            if (w_rd) r_rptr <= r_rptr + WIDTHU'(1);
            r_count <= r_count + (WIDTHU+1)'(w_wr) - (WIDTHU+1)'(w_rd);
        end

`ifdef SYNC_FIFO_SHOWAHEAD_EN
    assign q = w_rdata;
`else
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clock)
        if (!reset_n) r_q <= '0;
        else if (w_rd) r_q <= w_rdata;

    assign q = r_q;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed vector table plus hand-written full-boundary and show-ahead sequences.
module tb_sync_fifo;
    logic       clock = 0, reset_n = 0, wrreq = 0, rdreq = 0;
    logic [3:0] data = 0;
    logic [3:0] q;
    logic       empty, full;
    logic [4:0] usedw;

`ifdef SYNC_FIFO_SHOWAHEAD_EN
    localparam bit LEGACY = 0;
`else
    localparam bit LEGACY = 1;
`endif

    sync_fifo #(.WIDTH(4), .DEPTH(32), .WIDTHU(5)) dut (
        .clock(clock), .reset_n(reset_n), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .q(q), .empty(empty), .full(full), .usedw(usedw)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst_n, wr, rd;
        logic [3:0] d;
        logic [3:0] q;
        logic       e, f;
        logic [4:0] u;
    } vec_t;

    vec_t vecs[$];
    int checks = 0, errors = 0;

    function automatic void add(input logic rn, w, r, input logic [3:0] d, input logic [3:0] eq,
                                input logic ee, ef, input logic [4:0] eu);
        vec_t v;
        v = '{rn, w, r, d, eq, ee, ef, eu};
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [3:0] eq, input logic ee, ef,
                        input logic [4:0] eu, input bit cq);
        chk({tag, " empty"}, 32'(empty), 32'(ee));
        chk({tag, " full"}, 32'(full), 32'(ef));
        chk({tag, " usedw"}, 32'(usedw), 32'(eu));
        if (cq) chk({tag, " q"}, 32'(q), 32'(eq));
    endtask

    // inputs change 1 time unit after the rising edge; outputs are sampled there too
    task automatic step(input logic rn, w, r, input logic [3:0] d);
        reset_n = rn; wrreq = w; rdreq = r; data = d;
        @(posedge clock);
        #1;
    endtask

    initial begin
        add(0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 1, 1, 3, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) add(1, 1, 0, 4'(i), 0, 0, 0, 5'(i + 1));
        for (int i = 0; i < 8; i++) add(1, 0, 1, 0, 4'(i), i == 7, 0, 5'(7 - i));
        add(1, 0, 1, 0, 7, 1, 0, 0);
        add(1, 1, 0, 5, 7, 0, 0, 1);
        add(1, 0, 1, 0, 5, 1, 0, 0);
        add(1, 0, 1, 0, 5, 1, 0, 0);
        add(1, 1, 0, 9, 5, 0, 0, 1);
        add(1, 0, 1, 0, 9, 1, 0, 0);
        for (int i = 1; i <= 3; i++) add(1, 1, 0, 4'(i), 9, 0, 0, 5'(i));
        add(1, 1, 1, 4, 1, 0, 0, 3);
        add(1, 0, 1, 0, 2, 0, 0, 2);
        add(1, 0, 1, 0, 3, 0, 0, 1);
        add(1, 0, 1, 0, 4, 1, 0, 0);
        add(1, 1, 1, 6, 4, 0, 0, 1);
        add(1, 0, 1, 0, 6, 1, 0, 0);
        for (int i = 0; i < 10; i++) add(1, 1, 0, 4'(i), 6, 0, 0, 5'(i + 1));
        add(0, 1, 1, 10, 0, 1, 0, 0);
        add(1, 0, 1, 0, 0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].wr, vecs[i].rd, vecs[i].d);
            outs($sformatf("vec%0d", i), vecs[i].q, vecs[i].e, vecs[i].f, vecs[i].u, LEGACY);
        end

        for (int i = 0; i < 33; i++) begin
            step(1, 1, 0, 4'(i % 16));
            if (i >= 31) outs($sformatf("fill%0d", i), 0, 0, 1, 0, 0);
        end
        step(1, 1, 1, 7);
        outs("full_simul", 0, 0, 0, 31, LEGACY);
        for (int i = 1; i < 32; i++) begin
            step(1, 0, 1, 0);
            outs($sformatf("drain%0d", i), 4'(i % 16), i == 31, 0, 5'(31 - i), LEGACY);
        end
        step(1, 0, 1, 0);
        outs("drain_extra", 15, 1, 0, 0, LEGACY);

        if (!LEGACY) begin
            step(0, 0, 0, 0);
            for (int i = 0; i < 8; i++) step(1, 1, 0, 4'(i + 8));
            outs("sa_head", 8, 0, 0, 8, 1);
            for (int i = 0; i < 7; i++) begin
                step(1, 0, 1, 0);
                outs($sformatf("sa_rd%0d", i), 4'(i + 9), 0, 0, 5'(7 - i), 1);
            end
            step(1, 0, 1, 0);
            outs("sa_last", 0, 1, 0, 0, 0);
        end

        step(1, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
